// File: rtl/legv8_pkg.sv
// legv8_pkg: shared definitions for the LEGv8 front end.
//   - fetch_state_e : fetch FSM states (also exported on the debug port)
//   - instruction field positions (opcode, B and CBZ immediates)
//   - PC increment and the opcode constants used by the controller
package legv8_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  localparam int OPC_MSB     = 31;
  localparam int OPC_LSB     = 21;
  localparam int OPC_W       = OPC_MSB - OPC_LSB + 1;

  localparam int B_IMM_MSB   = 25;
  localparam int B_IMM_LSB   = 0;
  localparam int B_IMM_W     = B_IMM_MSB - B_IMM_LSB + 1;

  localparam int CBZ_IMM_MSB = 23;
  localparam int CBZ_IMM_LSB = 5;
  localparam int CBZ_IMM_W   = CBZ_IMM_MSB - CBZ_IMM_LSB + 1;

  localparam int PC_INCR     = 4;

  // Controller opcodes (full 11-bit R/D-format; B and CBZ match on a prefix)
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [5:0]  OPC_B_PREFIX   = 6'b000101;
  localparam logic [7:0]  OPC_CBZ_PREFIX = 8'b10110100;

endpackage

// File: rtl/legv8_fetch_unit_if.sv
// legv8_fetch_unit_if: bundles the fetch unit's two handshakes.
//   imem_req_*  : request channel to instruction memory (fetch -> memory)
//   imem_resp_* : response pulse from memory, one per accepted request
//   instr_*     : instruction presented to decode, plus decoder branch flags
// Handshake rule (both valid/ready channels): a transfer happens in the
// cycle where valid and ready are both high; once valid rises, the payload
// stays stable and valid stays high until that transfer cycle.
// modport master = fetch unit side, modport slave = memory/decode side.
interface legv8_fetch_unit_if #(
  parameter int PC_WIDTH    = 64,
  parameter int INSTR_WIDTH = 32
);
  logic                          imem_req_valid;
  logic                          imem_req_ready;
  logic [PC_WIDTH-1:0]           imem_req_addr;
  logic                          imem_resp_valid;
  logic [INSTR_WIDTH-1:0]        imem_resp_data;
  logic                          instr_valid;
  logic                          instr_ready;
  logic [INSTR_WIDTH-1:0]        instr;
  logic [legv8_pkg::OPC_W-1:0]   opcode;
  logic [PC_WIDTH-1:0]           instr_pc;
  logic                          isZeroBranch;
  logic                          isUnconBranch;
  logic                          aluZero;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output instr_valid, instr, opcode, instr_pc,
    input  instr_ready, isZeroBranch, isUnconBranch, aluZero
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  instr_valid, instr, opcode, instr_pc,
    output instr_ready, isZeroBranch, isUnconBranch, aluZero
  );
endinterface

// File: rtl/legv8_next_pc.sv
// legv8_next_pc: combinational next-PC selection.
//   instr_pc_i        : address of the instruction being retired
//   imm_i             : instr[25:0] (holds both the B and CBZ immediates)
//   is_uncon_branch_i : B; wins over CBZ
//   is_zero_branch_i  : CBZ, taken when alu_zero_i is set
//   next_pc_o         : branch target or instr_pc_i + 4 (modulo 2^PC_WIDTH)
module legv8_next_pc
  import legv8_pkg::*;
#(
  parameter int PC_WIDTH = 64
) (
  input  logic [PC_WIDTH-1:0] instr_pc_i,
  input  logic [B_IMM_W-1:0]  imm_i,
  input  logic                is_uncon_branch_i,
  input  logic                is_zero_branch_i,
  input  logic                alu_zero_i,
  output logic [PC_WIDTH-1:0] next_pc_o
);
  logic [PC_WIDTH-1:0] b_ext, cbz_ext, b_off, cbz_off;

  assign b_ext   = {{(PC_WIDTH-B_IMM_W){imm_i[B_IMM_MSB]}}, imm_i[B_IMM_MSB:B_IMM_LSB]};
  assign cbz_ext = {{(PC_WIDTH-CBZ_IMM_W){imm_i[CBZ_IMM_MSB]}}, imm_i[CBZ_IMM_MSB:CBZ_IMM_LSB]};
  // Word offsets -> byte offsets
  assign b_off   = {b_ext[PC_WIDTH-3:0], 2'b00};
  assign cbz_off = {cbz_ext[PC_WIDTH-3:0], 2'b00};

  always_comb begin
    next_pc_o = instr_pc_i + PC_WIDTH'(PC_INCR);
    if (is_uncon_branch_i) begin
      next_pc_o = instr_pc_i + b_off;
    end else if (is_zero_branch_i && alu_zero_i) begin
      next_pc_o = instr_pc_i + cbz_off;
    end
  end
endmodule

// File: rtl/legv8_fetch_unit.sv
// legv8_fetch_unit: LEGv8 instruction fetch stage.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : legv8_fetch_unit_if.master (imem request/response, decode
//                handshake, branch flags)
//   pc_out     : current fetch PC
//   state_o    : FSM state, for observation only
// One request outstanding at most: REQ -> WAIT -> HOLD -> REQ.
// Reset during WAIT moves to DRAIN so the in-flight response is swallowed.
module legv8_fetch_unit
  import legv8_pkg::*;
#(
  parameter int                  PC_WIDTH    = 64,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                clk,
  input  logic                reset,
  legv8_fetch_unit_if.master  bus,
  output logic [PC_WIDTH-1:0] pc_out,
  output fetch_state_e        state_o
);
  fetch_state_e           state_q, state_d, state_rst;
  logic [PC_WIDTH-1:0]    pc_q, pc_d, instr_pc_q, instr_pc_d, next_pc;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   instr_valid_q, instr_valid_d;
  logic                   req_valid;

  legv8_next_pc #(.PC_WIDTH(PC_WIDTH)) u_next_pc (
    .instr_pc_i        (instr_pc_q),
    .imm_i             (instr_q[B_IMM_MSB:B_IMM_LSB]),
    .is_uncon_branch_i (bus.isUnconBranch),
    .is_zero_branch_i  (bus.isZeroBranch),
    .alu_zero_i        (bus.aluZero),
    .next_pc_o         (next_pc)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    req_valid     = 1'b0;
    case (state_q)
      REQ: begin
        // Masked during reset so no request is accepted while it is asserted
        req_valid = !reset;
        if (req_valid && bus.imem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (bus.imem_resp_valid) begin
          instr_d       = bus.imem_resp_data;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        if (bus.instr_ready) begin
          pc_d          = next_pc;
          instr_valid_d = 1'b0;
          state_d       = REQ;
        end
      end
      DRAIN: begin
        if (bus.imem_resp_valid) state_d = REQ;
      end
      default: state_d = REQ;
    endcase
  end

  // State taken when reset is sampled. A response landing in the same cycle
  // as reset in WAIT/DRAIN already retires the request, so nothing is left
  // to drain.
  always_comb begin
    state_rst = REQ;
    if (state_q == WAIT || state_q == DRAIN) begin
      state_rst = bus.imem_resp_valid ? REQ : DRAIN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= state_rst;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.instr_valid    = instr_valid_q && !reset;
  assign bus.instr          = instr_q;
  assign bus.opcode         = instr_q[OPC_MSB:OPC_LSB];
  assign bus.instr_pc       = instr_pc_q;
  assign pc_out             = pc_q;
  assign state_o            = state_q;
endmodule
